// File: rtl/cpu_sequencer.sv
// FETCH/EXEC1/EXEC2 instruction-cycle sequencer for the teaching CPU: fetch handshake,
// run/single-step control, halt, fetch timeout and a retired-instruction counter.
module cpu_sequencer #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step,
  input  logic             mem_ack,
  input  logic             extra,
  input  logic             halt_instr,
  input  logic             clr_halt,
  output logic             fetch,
  output logic             exec1,
  output logic             exec2,
  output logic             mem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             retire,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned WaitW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec1,
    StExec2,
    StHalt
  } state_e;

  state_e             state_q;
  state_e             after_instr;
  logic               step_mode_q;
  logic [WaitW-1:0]   wait_cnt_q;
  logic [WaitW-1:0]   wait_inc;
  logic               wait_expired;
  logic               timeout_q;
  logic [CNT_W-1:0]   instr_cnt_q;

  assign wait_inc     = wait_cnt_q + 1'b1;
  // The cycle that would bring the no-ack count up to MAX_WAIT is the last FETCH cycle.
  assign wait_expired = (MAX_WAIT != 0) && (wait_inc == WaitW'(MAX_WAIT));
  assign after_instr  = (step_mode_q || !run) ? StIdle : StFetch;

  assign fetch   = (state_q == StFetch);
  assign exec1   = (state_q == StExec1);
  assign exec2   = (state_q == StExec2);
  assign halted  = (state_q == StHalt);
  assign mem_req = fetch;
  assign ir_load = fetch & mem_ack;
  assign pc_inc  = fetch & mem_ack;
  assign retire  = (exec1 & (halt_instr | ~extra)) | exec2;

  assign timeout   = timeout_q;
  assign instr_cnt = instr_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      step_mode_q <= 1'b0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      if (retire) begin
        instr_cnt_q <= instr_cnt_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (run) begin
            state_q     <= StFetch;
            step_mode_q <= 1'b0;
          end else if (step) begin
            state_q     <= StFetch;
            step_mode_q <= 1'b1;
          end
        end
        StFetch: begin
          if (mem_ack) begin
            state_q    <= StExec1;
            wait_cnt_q <= '0;
          end else if (wait_expired) begin
            state_q    <= StHalt;
            timeout_q  <= 1'b1;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_inc;
          end
        end
        StExec1: begin
          if (halt_instr) begin
            state_q <= StHalt;
          end else if (extra) begin
            state_q <= StExec2;
          end else begin
            state_q <= after_instr;
          end
        end
        StExec2: state_q <= after_instr;
        StHalt: begin
          if (clr_halt) begin
            state_q   <= StIdle;
            timeout_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: free run, single step, halt, fetch timeout,
// async reset mid-instruction and counter wrap (CNT_W = 4).
module tb_cpu_sequencer;

  logic       clk;
  logic       reset_n;
  logic       run, step, mem_ack, extra, halt_instr, clr_halt;
  logic       fetch, exec1, exec2, mem_req, ir_load, pc_inc, retire, halted, timeout;
  logic [3:0] instr_cnt;
  logic [8:0] status;

  int checks   = 0;
  int failures = 0;

  // status = {fetch, exec1, exec2, halted, mem_req, ir_load, pc_inc, retire, timeout}
  localparam logic [8:0] Idle      = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] FetchAck  = 9'b1_0_0_0_1_1_1_0_0;
  localparam logic [8:0] FetchWait = 9'b1_0_0_0_1_0_0_0_0;
  localparam logic [8:0] Exec1Ret  = 9'b0_1_0_0_0_0_0_1_0;
  localparam logic [8:0] Exec1Ext  = 9'b0_1_0_0_0_0_0_0_0;
  localparam logic [8:0] Exec2Ret  = 9'b0_0_1_0_0_0_0_1_0;
  localparam logic [8:0] Halt      = 9'b0_0_0_1_0_0_0_0_0;
  localparam logic [8:0] HaltTo    = 9'b0_0_0_1_0_0_0_0_1;

  assign status = {fetch, exec1, exec2, halted, mem_req, ir_load, pc_inc, retire, timeout};

  cpu_sequencer #(
    .CNT_W    (4),
    .MAX_WAIT (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .step       (step),
    .mem_ack    (mem_ack),
    .extra      (extra),
    .halt_instr (halt_instr),
    .clr_halt   (clr_halt),
    .fetch      (fetch),
    .exec1      (exec1),
    .exec2      (exec2),
    .mem_req    (mem_req),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .retire     (retire),
    .halted     (halted),
    .timeout    (timeout),
    .instr_cnt  (instr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    {run, step, mem_ack, extra, halt_instr, clr_halt} = '0;
    cyc();
    cyc();
    #1;
    chk("reset_status", 32'(status), 32'(Idle));
    chk("reset_cnt", 32'(instr_cnt), 0);

    // Free run, single-cycle fetch, no EXTRA
    reset_n = 1'b1;
    run     = 1'b1;
    mem_ack = 1'b1;
    #1;
    chk("idle_before_run", 32'(status), 32'(Idle));
    for (int i = 0; i < 10; i++) begin
      cyc();
      #1;
      chk("run_status", 32'(status), 32'((i % 2 == 0) ? FetchAck : Exec1Ret));
      chk("run_cnt", 32'(instr_cnt), 32'(i / 2));
    end
    cyc();
    #1;
    chk("run_10cyc_status", 32'(status), 32'(FetchAck));
    chk("run_10cyc_cnt", 32'(instr_cnt), 5);
    cyc();
    run = 1'b0;
    #1;
    chk("run_drop_exec1", 32'(status), 32'(Exec1Ret));
    cyc();
    #1;
    chk("run_drop_idle", 32'(status), 32'(Idle));
    chk("run_drop_cnt", 32'(instr_cnt), 6);

    // Single step with EXTRA and a 3-cycle fetch
    mem_ack = 1'b0;
    extra   = 1'b1;
    step    = 1'b1;
    cyc();
    step = 1'b0;
    #1;
    chk("step_fetch1", 32'(status), 32'(FetchWait));
    cyc();
    step = 1'b1;
    #1;
    chk("step_fetch2", 32'(status), 32'(FetchWait));
    cyc();
    step    = 1'b0;
    mem_ack = 1'b1;
    #1;
    chk("step_fetch3", 32'(status), 32'(FetchAck));
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("step_exec1", 32'(status), 32'(Exec1Ext));
    chk("step_exec1_cnt", 32'(instr_cnt), 6);
    cyc();
    #1;
    chk("step_exec2", 32'(status), 32'(Exec2Ret));
    cyc();
    extra = 1'b0;
    #1;
    chk("step_idle", 32'(status), 32'(Idle));
    chk("step_cnt", 32'(instr_cnt), 7);

    // RUN beats STEP, then HALT instruction (EXTRA ignored)
    run     = 1'b1;
    step    = 1'b1;
    mem_ack = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    #1;
    chk("prio_exec1", 32'(status), 32'(Exec1Ret));
    cyc();
    #1;
    chk("prio_refetch", 32'(status), 32'(FetchAck));
    chk("prio_cnt", 32'(instr_cnt), 8);
    cyc();
    halt_instr = 1'b1;
    extra      = 1'b1;
    #1;
    chk("halt_exec1", 32'(status), 32'(Exec1Ret));
    cyc();
    halt_instr = 1'b0;
    extra      = 1'b0;
    step       = 1'b1;
    #1;
    chk("halt_state", 32'(status), 32'(Halt));
    chk("halt_cnt", 32'(instr_cnt), 9);
    cyc();
    step = 1'b0;
    #1;
    chk("halt_ignores_run", 32'(status), 32'(Halt));
    clr_halt = 1'b1;
    cyc();
    clr_halt = 1'b0;
    run      = 1'b0;
    #1;
    chk("halt_cleared", 32'(status), 32'(Idle));

    // Fetch timeout after 8 FETCH cycles; CLR_HALT mid-fetch has no effect
    run     = 1'b1;
    mem_ack = 1'b0;
    cyc();
    for (int k = 1; k <= 8; k++) begin
      clr_halt = (k == 3);
      #1;
      chk("to_fetch_wait", 32'(status), 32'(FetchWait));
      if (k < 8) cyc();
    end
    clr_halt = 1'b0;
    cyc();
    run = 1'b0;
    #1;
    chk("to_halt", 32'(status), 32'(HaltTo));
    chk("to_cnt", 32'(instr_cnt), 9);
    cyc();
    #1;
    chk("to_sticky", 32'(status), 32'(HaltTo));
    clr_halt = 1'b1;
    cyc();
    clr_halt = 1'b0;
    #1;
    chk("to_cleared", 32'(status), 32'(Idle));
    chk("to_cnt_kept", 32'(instr_cnt), 9);

    // Async reset while in EXEC2
    run     = 1'b1;
    mem_ack = 1'b1;
    extra   = 1'b1;
    cyc();
    cyc();
    cyc();
    #1;
    chk("rst_in_exec2", 32'(status), 32'(Exec2Ret));
    reset_n = 1'b0;
    #1;
    chk("rst_async_status", 32'(status), 32'(Idle));
    chk("rst_async_cnt", 32'(instr_cnt), 0);
    cyc();
    #1;
    chk("rst_held", 32'(status), 32'(Idle));
    reset_n = 1'b1;
    extra   = 1'b0;

    // 17 instructions on a 4-bit counter: 15 -> 0 -> 1
    for (int n = 1; n <= 35; n++) begin
      cyc();
      #1;
      if (n == 31) chk("wrap_cnt15", 32'(instr_cnt), 15);
      if (n == 33) chk("wrap_cnt0", 32'(instr_cnt), 0);
      if (n == 35) chk("wrap_cnt1", 32'(instr_cnt), 1);
    end
    run = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
